// File: rtl/norm_seq_pkg.sv
// Shared types and default sizing for the normalizer row sequencer.
package norm_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        ISSUE,
        COLLECT,
        WRITE
    } state_t;

    localparam int DEF_BW_PSUM  = 16;
    localparam int DEF_COL      = 8;
    localparam int DEF_W_OUT    = DEF_BW_PSUM;
    localparam int DEF_ROWS_MAX = 16;
    localparam int DEF_TIMEOUT  = 64;

endpackage

// File: rtl/norm_row_collector.sv
// Packs the two serial normalizer streams back into rows. Both streams share
// one element index; beat k lands at bits [k*W +: W] of each row.
module norm_row_collector #(
    parameter int COL = 8,
    parameter int W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             beat_en,
    input  logic [W-1:0]     din_1,
    input  logic [W-1:0]     din_2,
    output logic [COL*W-1:0] row_1,
    output logic [COL*W-1:0] row_2,
    output logic             full
);

    localparam int IW = (COL > 1) ? $clog2(COL) : 1;

    logic [IW-1:0] idx;

    // The accepted beat is the last element of the row.
    assign full = beat_en && (idx == IW'(COL - 1));

    // Element index: restarts on clear and wraps after a full row.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx <= '0;
        end else if (clear) begin
            idx <= '0;
        end else if (beat_en) begin
            idx <= full ? '0 : idx + 1'b1;
        end
    end

    // Drop each accepted beat into its element slot of both rows.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_1 <= '0;
            row_2 <= '0;
        end else if (beat_en) begin
            row_1[idx*W +: W] <= din_1;
            row_2[idx*W +: W] <= din_2;
        end
    end

endmodule

// File: rtl/norm_row_sequencer.sv
// Row-level controller for the normalizer: reads a psum row pair, issues it,
// collects COL serial beats per stream, writes the packed rows back, one row
// at a time, with a watchdog on the collect phase.
module norm_row_sequencer
    import norm_seq_pkg::*;
#(
    parameter int BW_PSUM  = DEF_BW_PSUM,
    parameter int COL      = DEF_COL,
    parameter int W_OUT    = BW_PSUM,
    parameter int ROWS_MAX = DEF_ROWS_MAX,
    parameter int TIMEOUT  = DEF_TIMEOUT
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [$clog2(ROWS_MAX):0]   num_rows,
    output logic                        busy,
    output logic                        done,
    output logic                        error,
    output logic                        psum_rd_en,
    output logic [$clog2(ROWS_MAX)-1:0] psum_rd_addr,
    input  logic [COL*BW_PSUM-1:0]      psum_rd_data_1,
    input  logic [COL*BW_PSUM-1:0]      psum_rd_data_2,
    output logic                        norm_s_valid_1,
    output logic                        norm_s_valid_2,
    output logic [COL*BW_PSUM-1:0]      norm_psum_1,
    output logic [COL*BW_PSUM-1:0]      norm_psum_2,
    input  logic [W_OUT-1:0]            norm_in_1,
    input  logic [W_OUT-1:0]            norm_in_2,
    input  logic                        norm_valid,
    output logic                        out_wr_en,
    output logic [$clog2(ROWS_MAX)-1:0] out_wr_addr,
    output logic [COL*W_OUT-1:0]        out_wr_data_1,
    output logic [COL*W_OUT-1:0]        out_wr_data_2
);

    localparam int AW = $clog2(ROWS_MAX);
    localparam int NW = AW + 1;
    localparam int WW = $clog2(TIMEOUT + 1);

    state_t        state, state_nxt;
    logic [AW-1:0] row_cnt;
    logic [NW-1:0] rows_lat;
    logic [NW-1:0] rows_sat;
    logic [WW-1:0] wd_cnt;
    logic          start_acc;
    logic          wd_expire;
    logic          beat_en;
    logic          last_row;
    logic          row_full;

    assign start_acc = (state == IDLE) && start;
    assign rows_sat  = (num_rows > NW'(ROWS_MAX)) ? NW'(ROWS_MAX) : num_rows;
    assign wd_expire = (state == COLLECT) && (wd_cnt == WW'(TIMEOUT - 1));
    // A beat arriving in the expiry cycle is dropped: the timeout wins.
    assign beat_en   = (state == COLLECT) && norm_valid && !wd_expire;
    assign last_row  = ({1'b0, row_cnt} == rows_lat - NW'(1));

    assign busy           = (state != IDLE);
    assign psum_rd_en     = (state == READ);
    assign psum_rd_addr   = row_cnt;
    assign norm_s_valid_1 = (state == ISSUE);
    assign norm_s_valid_2 = (state == ISSUE);
    assign out_wr_en      = (state == WRITE);
    assign out_wr_addr    = row_cnt;

    norm_row_collector #(
        .COL (COL),
        .W   (W_OUT)
    ) u_collector (
        .clk     (clk),
        .reset   (reset),
        .clear   (start_acc || (state == ISSUE)),
        .beat_en (beat_en),
        .din_1   (norm_in_1),
        .din_2   (norm_in_2),
        .row_1   (out_wr_data_1),
        .row_2   (out_wr_data_2),
        .full    (row_full)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state decode; a zero-row pass never leaves IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && (rows_sat != '0)) state_nxt = READ;
            READ:    state_nxt = ISSUE;
            ISSUE:   state_nxt = COLLECT;
            COLLECT: begin
                if (wd_expire)     state_nxt = IDLE;
                else if (row_full) state_nxt = WRITE;
            end
            WRITE:   state_nxt = last_row ? IDLE : READ;
            default: state_nxt = IDLE;
        endcase
    end

    // Latch the saturated row count on accept and advance the row address after each write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rows_lat <= '0;
            row_cnt  <= '0;
        end else if (start_acc) begin
            rows_lat <= rows_sat;
            row_cnt  <= '0;
        end else if ((state == WRITE) && !last_row) begin
            row_cnt <= row_cnt + 1'b1;
        end
    end

    // Watchdog: counts cycles spent in COLLECT, restarted at every issue.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_cnt <= '0;
        end else if (start_acc || (state == ISSUE)) begin
            wd_cnt <= '0;
        end else if (state == COLLECT) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    // End-of-pass pulse and sticky timeout flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done  <= 1'b0;
            error <= 1'b0;
        end else begin
            done <= (start_acc && (rows_sat == '0)) || ((state == WRITE) && last_row) || wd_expire;
            if (start_acc)      error <= 1'b0;
            else if (wd_expire) error <= 1'b1;
        end
    end

    // Capture the buffer rows while issuing; held stable for the normalizer's accept stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            norm_psum_1 <= '0;
            norm_psum_2 <= '0;
        end else if (state == ISSUE) begin
            norm_psum_1 <= psum_rd_data_1;
            norm_psum_2 <= psum_rd_data_2;
        end
    end

endmodule

// File: doc/norm_row_sequencer.md
# norm_row_sequencer

Row-level controller for the softmax-style normalizer. It reads psum rows for both cores from a synchronous psum buffer and issues each row pair to the normalizer. It then collects the COL serial normalized beats per stream, packs them back into rows and writes them to the output buffer. It runs one row at a time under a start/done handshake from the top-level controller, with a watchdog for a stalled normalizer.

## Interface
- BW_PSUM, 16, psum element width
- COL, 8, elements per row
- W_OUT, BW_PSUM, normalized element width
- ROWS_MAX, 16, output/psum buffer depth in rows
- TIMEOUT, 64, max cycles from issue to last beat; must be > 2*COL+8
- clk  in  1  single clock
- reset  in  1  asynchronous, active-high
- start  in  1  begin a pass; sampled only when idle
- num_rows  in  $clog2(ROWS_MAX)+1  rows in pass; saturates to ROWS_MAX
- busy  out  1  pass in progress
- done  out  1  one-cycle pulse at end of pass
- error  out  1  sticky watchdog flag; cleared by next accepted start
- psum_rd_en  out  1  buffer read strobe
- psum_rd_addr  out  $clog2(ROWS_MAX)  row address
- psum_rd_data_1, psum_rd_data_2  in  COL*BW_PSUM  rows, valid the cycle after psum_rd_en
- norm_s_valid_1, norm_s_valid_2  out  1  issue strobes to normalizer
- norm_psum_1, norm_psum_2  out  COL*BW_PSUM  registered row to normalizer
- norm_in_1, norm_in_2  in  W_OUT  normalizer serial outputs
- norm_valid  in  1  normalizer beat valid
- out_wr_en  out  1  output buffer write strobe
- out_wr_addr  out  $clog2(ROWS_MAX)  row address
- out_wr_data_1, out_wr_data_2  out  COL*W_OUT  packed rows

## Operation
- States: IDLE, READ, ISSUE, COLLECT, WRITE.
- IDLE: on start=1, latch num_rows (saturated), clear row counter, beat counter and error.
  - If latched count = 0: pulse done next cycle, stay IDLE, no reads.
  - Otherwise go to READ.
- READ: assert psum_rd_en for one cycle with psum_rd_addr = row counter. Go to ISSUE.
- ISSUE: register both read rows into norm_psum_1/2. Assert norm_s_valid_1 and norm_s_valid_2 together for exactly one cycle. Clear beat counter and watchdog. Go to COLLECT.
- COLLECT: each norm_valid=1 cycle stores norm_in_1/2 at element index = beat counter. The first beat is element 0, at bits [W_OUT-1:0]. Increment the beat counter. On beat COL-1, go to WRITE.
- WRITE: assert out_wr_en for one cycle with out_wr_addr = row counter and the packed rows.
  - If row counter = latched count-1: go to IDLE and pulse done.
  - Otherwise increment row counter and go to READ.
- Watchdog: counts cycles in COLLECT. On reaching TIMEOUT: set error, skip the write, go to IDLE, pulse done.
- Ignored inputs:
  - norm_valid outside COLLECT.
  - start while busy.
- busy = (state != IDLE).

## Timing
- Reset: every output is 0, state IDLE, all counters 0.
- Reset mid-pass takes effect immediately. No partial write completes, and no done pulse is produced.
- Start accepted in cycle t:
  - t+1: READ (psum_rd_en=1).
  - t+2: ISSUE (norm_s_valid=1).
  - t+3 onward: COLLECT.
- Last beat at cycle c: WRITE at c+1; READ of the next row, or done, at c+2.
- With the normalizer behaving nominally (1 accept + COL sum + COL div + 3 pipe), the row period is 2*COL+7 cycles.
- A norm_valid coinciding with the watchdog expiry is discarded; timeout wins.
- Only one row is in flight at a time. Issue never overlaps collection, so normalizer sum/clear hazards cannot occur.

## Structure
- Package norm_seq_pkg holds:
  - the state enum typedef (IDLE, READ, ISSUE, COLLECT, WRITE);
  - default constants for BW_PSUM, COL, W_OUT, ROWS_MAX, TIMEOUT.
- Sub-module norm_row_collector: dual-stream beat-to-row packer with index counter, clear and full flag. Instantiated once, with both streams sharing the index.
- The FSM, address counters and watchdog stay in the top module.

## Test plan
- COL=8, num_rows=3, model normalizer returning beat k = 10*row+k: three writes at addresses 0,1,2 with element k = 10*row+k; done one cycle after the third write; error=0.
- num_rows=0: done pulses in the cycle after start; psum_rd_en, norm_s_valid and out_wr_en never assert.
- Model stalls after 5 beats on row 1: error=1 exactly TIMEOUT cycles after COLLECT entry; only row 0 written; done pulses; the next start clears error.
- start re-asserted every cycle during a 2-row pass, and stray norm_valid pulses injected in READ/ISSUE/WRITE: exactly 2 writes with correct data; a single done.
- Async reset asserted mid-COLLECT of row 1: all outputs 0 immediately, no write to address 1; after release, start with num_rows=1 completes normally.
- num_rows=ROWS_MAX+1 (17): exactly 16 rows processed, addresses 0..15.
